// File: rtl/ex_div_ctrl.sv
// Execute-stage controller for the iterative 32-bit divider: accepts DIV/MOD ops,
// sequences the divider, and hands the selected result to the memory stage.
module ex_div_ctrl #(
  parameter int unsigned MAX_LAT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        div_en,
  output logic        div_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [63:0] div_result,
  input  logic        div_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t        state, state_n;
  logic [1:0]    op;
  logic [CW-1:0] wd_cnt;
  logic          accept_c, capture_c, timeout_c, wd_hit_c, wd_clr_c;

  assign div_en   = (state == BUSY) | (state == DRAIN);
  assign div_sign = ~op[1];
  assign wd_hit_c = (wd_cnt == CW'(MAX_LAT - 1));
  assign wd_clr_c = (state_n != state) && ((state_n == BUSY) || (state_n == DRAIN));

  // Next-state and per-cycle action decode
  always_comb begin
    state_n   = state;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept_c = 1'b1;
          state_n  = (in_src2 == 32'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (div_done) begin
          capture_c = !flush;
          state_n   = flush ? IDLE : DONE;
        end else if (wd_hit_c) begin
          timeout_c = 1'b1;
          state_n   = IDLE;
        end else if (flush) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (div_done) begin
          state_n = IDLE;
        end else if (wd_hit_c) begin
          timeout_c = 1'b1;
          state_n   = IDLE;
        end
      end
      DONE: begin
        if (flush || out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Held operands, result capture, handshake flags and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      op           <= 2'b00;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      out_data     <= 32'd0;
      out_rd       <= 5'd0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (accept_c) begin
        op           <= in_op;
        div_dividend <= in_src1;
        div_divisor  <= in_src2;
        out_rd       <= in_rd;
        // Divide-by-zero bypass: all-ones quotient, dividend as remainder
        if (in_src2 == 32'd0) out_data <= in_op[0] ? in_src1 : 32'hFFFF_FFFF;
      end
      if (capture_c) out_data <= op[0] ? div_result[63:32] : div_result[31:0];
      if (timeout_c) timeout_err <= 1'b1;
      if (wd_clr_c)    wd_cnt <= '0;
      else if (div_en) wd_cnt <= wd_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl with a 34-cycle stub divider.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, div_en, div_sign, div_done;
  logic        out_valid, out_ready, timeout_err, hang;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2, div_dividend, div_divisor, out_data;
  logic [4:0]  in_rd, out_rd;
  logic [63:0] div_result;
  logic [5:0]  scnt;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_div_ctrl #(.MAX_LAT(40)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .flush(flush), .div_en(div_en), .div_sign(div_sign),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_result(div_result), .div_done(div_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .timeout_err(timeout_err)
  );

  // Stub divider: done on the 34th div_en-high cycle unless hung
  assign div_done = div_en && !hang && (scnt == 6'd33);

  always @(posedge clk) begin
    if (reset || !div_en || div_done) scnt <= 6'd0;
    else                              scnt <= scnt + 6'd1;
  end

  always_comb begin
    div_result = 64'd0;
    if (div_divisor != 32'd0) begin
      if (div_sign)
        div_result = {32'($signed(div_dividend) % $signed(div_divisor)),
                      32'($signed(div_dividend) / $signed(div_divisor))};
      else
        div_result = {div_dividend % div_divisor, div_dividend / div_divisor};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream handshake pops and compares one expected result
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h rd=%0d expected=none", out_data, out_rd);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", 64'(out_data), 64'(e.data));
        check("sb_rd", 64'(out_rd), 64'(e.rd));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    check("accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input int hold);
    int k, en;
    logic sign_ok, stable;
    logic [31:0] d0;
    sb_q.push_back('{data: exp, rd: rd});
    issue(op, a, b, rd);
    k = 1; en = 0; sign_ok = 1'b1;
    while (!out_valid && k < 100) begin
      if (div_en) begin
        en++;
        if (div_sign !== ~op[1]) sign_ok = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    check("latency", 64'(k), 64'(lat));
    check("en_cycles", 64'(en), 64'(lat - 1));
    check("div_sign", 64'(sign_ok), 64'd1);
    if (hold > 0) begin
      d0 = out_data; stable = 1'b1;
      repeat (hold - 1) begin
        @(posedge clk); #1;
        if (out_data !== d0 || out_rd !== rd || !out_valid || in_ready) stable = 1'b0;
      end
      check("backpressure_stable", 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_ready", 64'(in_ready), 64'd1);
    check("post_hs_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int k, en, vc;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; hang = 1'b0;
    in_op = 2'b00; in_src1 = 32'd0; in_src2 = 32'd0; in_rd = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_div_en", 64'(div_en), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_operands", {div_dividend, div_divisor}, 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 35, 0);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 35, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'h7FFF_FFFF, 35, 5);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'h0000_0001, 35, 0);
    run_op(2'b00, 32'h0000_0055, 32'd0, 5'd5, 32'hFFFF_FFFF, 1, 0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 5'd6, 32'h0000_1234, 1, 0);

    // Flush during BUSY: divider drains, nothing delivered
    issue(2'b00, 32'd100, 32'd7, 5'd7);
    k = 1; en = 0; vc = 0;
    while (!in_ready && k < 100) begin
      if (div_en) en++;
      if (out_valid) vc++;
      if (k == 10) flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      k++;
    end
    check("drain_ready_cycle", 64'(k), 64'd35);
    check("drain_en_cycles", 64'(en), 64'd34);
    check("drain_no_valid", 64'(vc), 64'd0);
    run_op(2'b00, 32'd100, 32'd7, 5'd8, 32'd14, 35, 0);

    // Flush in DONE drops the result
    issue(2'b00, 32'd9, 32'd0, 5'd9);
    check("done_flush_valid_pre", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_valid", 64'(out_valid), 64'd0);
    check("done_flush_ready", 64'(in_ready), 64'd1);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = 2'b00; in_src1 = 32'd8; in_src2 = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", 64'(in_ready), 64'd1);
    check("idle_flush_valid", 64'(out_valid), 64'd0);

    // Watchdog with a hung divider
    hang = 1'b1;
    issue(2'b00, 32'd10, 32'd3, 5'd10);
    k = 1; en = 0; vc = 0;
    while (!in_ready && k < 200) begin
      if (div_en) en++;
      if (out_valid) vc++;
      @(posedge clk); #1;
      k++;
    end
    check("wd_en_cycles", 64'(en), 64'd40);
    check("wd_no_valid", 64'(vc), 64'd0);
    check("wd_err", 64'(timeout_err), 64'd1);
    check("wd_idle_div_en", 64'(div_en), 64'd0);
    hang = 1'b0;
    run_op(2'b01, 32'd10, 32'd3, 5'd11, 32'd1, 35, 0);
    check("wd_err_sticky", 64'(timeout_err), 64'd1);

    // Reset mid-operation
    issue(2'b10, 32'd50, 32'd5, 5'd12);
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 64'(in_ready), 64'd1);
    check("midrst_div_en", 64'(div_en), 64'd0);
    check("midrst_err_clr", 64'(timeout_err), 64'd0);
    @(negedge clk) reset = 1'b0;
    run_op(2'b10, 32'd50, 32'd5, 5'd13, 32'd10, 35, 0);

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
